// File: rtl/pigasus_sme_seq_pkg.sv
// rtl/pigasus_sme_seq_pkg.sv - shared state encoding and constants for the SME sequencer
package pigasus_sme_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RELOAD,
        STREAM,
        DRAIN,
        POLL,
        SETTLE,
        REPORT,
        STATUS
    } seq_state_t;

    localparam logic [15:0] TERM_INDEX = 16'hFFFF;
    localparam int          CNT_W      = 8;
    localparam int          TIMER_W    = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sme_seq_down_counter.sv
// rtl/sme_seq_down_counter.sv - loadable down counter with zero flag for drain/settle waits
module sme_seq_down_counter
    import pigasus_sme_seq_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Load wins over decrement so a new wait can start on the cycle the old one ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pigasus_sme_sequencer.sv
// rtl/pigasus_sme_sequencer.sv - per-packet reload/stream/drain/poll controller for the match engine
module pigasus_sme_sequencer
    import pigasus_sme_seq_pkg::*;
#(
    parameter int DRAIN_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 3,
    parameter int MAX_MATCHES   = 32,
    parameter int FLOW_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [FLOW_W-1:0] desc_flow_id,
    input  logic [63:0]       desc_flow_state,
    input  logic [127:0]      s_axis_tdata,
    input  logic [15:0]       s_axis_tkeep,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [127:0]      m_axis_tdata,
    output logic [15:0]       m_axis_tkeep,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              eng_reload,
    output logic [63:0]       eng_preamble_state,
    output logic              eng_next_index,
    input  logic [15:0]       eng_match_index,
    input  logic              eng_match_valid,
    input  logic [63:0]       eng_last_bytes_state,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [FLOW_W-1:0] res_flow_id,
    output logic [15:0]       res_index,
    output logic              res_last,
    output logic              sts_valid,
    input  logic              sts_ready,
    output logic [FLOW_W-1:0] sts_flow_id,
    output logic [63:0]       sts_flow_state,
    output logic [7:0]        sts_match_count,
    output logic              sts_overflow,
    output logic              busy
);

    seq_state_t         state;
    logic [FLOW_W-1:0]  flow_id;
    logic [CNT_W-1:0]   match_count;
    logic               overflow;
    logic               in_stream;
    logic               last_fire;
    logic               rec_fire;
    logic               drop_fire;
    logic               tmr_load;
    logic               tmr_zero;
    logic [TIMER_W-1:0] tmr_value;

    assign in_stream     = (state == STREAM);
    assign m_axis_tdata  = in_stream ? s_axis_tdata : '0;
    assign m_axis_tkeep  = in_stream ? s_axis_tkeep : '0;
    assign m_axis_tlast  = in_stream & s_axis_tlast;
    assign m_axis_tvalid = in_stream & s_axis_tvalid;
    assign s_axis_tready = in_stream & m_axis_tready;
    assign res_flow_id   = flow_id;

    assign last_fire = s_axis_tvalid & s_axis_tready & s_axis_tlast;
    assign rec_fire  = (state == POLL) & res_valid & res_ready;
    // Past the record limit a match is still popped from the engine, just not reported.
    assign drop_fire = (state == POLL) & ~res_valid & eng_match_valid
                     & (match_count == CNT_W'(MAX_MATCHES));
    assign tmr_load  = last_fire | rec_fire | drop_fire;
    assign tmr_value = last_fire ? TIMER_W'(DRAIN_CYCLES - 1) : TIMER_W'(SETTLE_CYCLES - 1);

    sme_seq_down_counter #(.W(TIMER_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .dec        ((state == DRAIN) || (state == SETTLE)),
        .zero       (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            desc_ready         <= 1'b0;
            busy               <= 1'b0;
            flow_id            <= '0;
            eng_reload         <= 1'b0;
            eng_preamble_state <= '0;
            eng_next_index     <= 1'b0;
            match_count        <= '0;
            overflow           <= 1'b0;
            res_valid          <= 1'b0;
            res_index          <= '0;
            res_last           <= 1'b0;
            sts_valid          <= 1'b0;
            sts_flow_id        <= '0;
            sts_flow_state     <= '0;
            sts_match_count    <= '0;
            sts_overflow       <= 1'b0;
        end else begin
            eng_reload     <= 1'b0;
            eng_next_index <= 1'b0;
            case (state)
                IDLE: begin
                    desc_ready <= 1'b1;
                    if (desc_valid && desc_ready) begin
                        desc_ready         <= 1'b0;
                        busy               <= 1'b1;
                        flow_id            <= desc_flow_id;
                        eng_preamble_state <= desc_flow_state;
                        eng_reload         <= 1'b1;
                        match_count        <= '0;
                        overflow           <= 1'b0;
                        state              <= RELOAD;
                    end
                end
                RELOAD: state <= STREAM;
                STREAM: if (last_fire) state <= DRAIN;
                DRAIN:  if (tmr_zero) state <= POLL;
                POLL: begin
                    if (rec_fire) begin
                        res_valid      <= 1'b0;
                        eng_next_index <= 1'b1;
                        match_count    <= sat_inc(match_count);
                        state          <= SETTLE;
                    end else if (drop_fire) begin
                        overflow       <= 1'b1;
                        eng_next_index <= 1'b1;
                        state          <= SETTLE;
                    end else if (!res_valid) begin
                        res_valid <= 1'b1;
                        if (eng_match_valid) begin
                            res_index <= eng_match_index;
                            res_last  <= 1'b0;
                        end else begin
                            res_index <= TERM_INDEX;
                            res_last  <= 1'b1;
                            state     <= REPORT;
                        end
                    end
                end
                SETTLE: if (tmr_zero) state <= POLL;
                REPORT: begin
                    if (res_ready) begin
                        res_valid       <= 1'b0;
                        res_last        <= 1'b0;
                        sts_valid       <= 1'b1;
                        sts_flow_id     <= flow_id;
                        sts_flow_state  <= eng_last_bytes_state;
                        sts_match_count <= match_count;
                        sts_overflow    <= overflow;
                        state           <= STATUS;
                    end
                end
                STATUS: begin
                    if (sts_ready) begin
                        sts_valid  <= 1'b0;
                        busy       <= 1'b0;
                        desc_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pigasus_sme_sequencer.md
Name: pigasus_sme_sequencer

Overview:
- Per-packet controller in front of the Pigasus fast-pattern match engine wrapper.
- Takes one job descriptor per packet: flow id plus 64-bit saved flow state (7 B tail data + 1 B len/valid).
- Sequences the engine through four steps: reload with preamble, stream the packet, drain the pipeline, pop every match index with next_index.
- Then reports the updated flow state (engine last-bytes state) on a status port. One packet in flight at a time.

Parameters:
- DRAIN_CYCLES, 16: cycles to wait after the engine accepts tlast before polling matches.
- SETTLE_CYCLES, 3: cycles to wait after each next_index pulse before resampling match_valid (covers the engine's registered mask/index path).
- MAX_MATCHES, 32: match records emitted per packet; further matches are dropped and flagged.
- FLOW_W, 16: flow id width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- desc_valid / desc_ready  in/out  1/1  job descriptor handshake
- desc_flow_id  in  FLOW_W  flow id
- desc_flow_state  in  64  saved preamble state
- s_axis_tdata/tkeep/tvalid/tlast/tready  in,in,in,in/out  128/16/1/1/1  packet payload
- m_axis_tdata/tkeep/tvalid/tlast/tready  out,out,out,out/in  128/16/1/1/1  payload to engine
- eng_reload  out  1  engine reload pulse
- eng_preamble_state  out  64  preamble to engine
- eng_next_index  out  1  pop-match pulse
- eng_match_index  in  16  engine match index
- eng_match_valid  in  1  engine match valid
- eng_last_bytes_state  in  64  engine tail state
- res_valid / res_ready  out/in  1/1  match record handshake
- res_flow_id  out  FLOW_W  flow id of match record
- res_index  out  16  match rule index
- res_last  out  1  last record of packet
- sts_valid / sts_ready  out/in  1/1  end-of-packet status handshake
- sts_flow_id  out  FLOW_W  flow id of status
- sts_flow_state  out  64  updated flow state
- sts_match_count  out  8  matches reported
- sts_overflow  out  1  matches were dropped
- busy  out  1  packet in flight

Behaviour:
- Reset (rst_n low, async): state IDLE. All valid/pulse outputs 0; desc_ready 0; busy 0; counters 0; data outputs 0.
- IDLE:
  - desc_ready=1. On desc_valid&desc_ready, latch flow id and state, go to RELOAD. busy=1 from the next cycle.
- RELOAD (1 cycle):
  - eng_reload=1, eng_preamble_state=latched state. eng_preamble_state holds until the next descriptor.
  - Go to STREAM.
- STREAM:
  - s_axis is passed through combinationally to m_axis only in this state; s_axis_tready = m_axis_tready in STREAM, else 0.
  - On the s_axis beat where tvalid&tready&tlast, go to DRAIN and load the counter with DRAIN_CYCLES-1.
- DRAIN:
  - Count down to 0, then go to POLL.
- POLL:
  - eng_match_valid=0 → go to REPORT with res_last pending.
  - eng_match_valid=1 → present a record: res_valid=1, res_index=eng_match_index captured into a register, res_last=0.
  - On res_ready: pulse eng_next_index for 1 cycle, increment count, go to SETTLE (counter=SETTLE_CYCLES-1).
  - If count==MAX_MATCHES, no record is presented: set overflow, pulse eng_next_index, go to SETTLE.
- SETTLE:
  - Count down, then return to POLL.
- REPORT:
  - If count>0 and not overflow, the last emitted record is not retroactively marked. Instead, a terminal record res_valid=1, res_index=16'hFFFF, res_last=1 is emitted. This applies even when count=0, so every packet yields exactly one res_last.
  - On res_ready, go to STATUS.
- STATUS:
  - sts_valid=1 with flow id, sts_flow_state=eng_last_bytes_state sampled on entry, sts_match_count (saturates 255), sts_overflow.
  - On sts_ready, go to IDLE. busy=0 in IDLE.
- Backpressure: res_valid/sts_valid hold with data stable until ready. A valid is never deasserted without a handshake.
- A zero-length packet is not legal: a single beat with tkeep=0 and tlast is passed through as-is.
- eng_reload and eng_next_index are never asserted in the same cycle.
- Reset mid-packet returns to IDLE immediately. The upstream source must resend the packet.

Decomposition:
- Package pigasus_sme_seq_pkg: state enum (IDLE, RELOAD, STREAM, DRAIN, POLL, SETTLE, REPORT, STATUS), TERM_INDEX=16'hFFFF, count width.
- One natural sub-module: sme_seq_down_counter, a loadable down counter with a zero flag, shared by DRAIN and SETTLE.

Test Plan:
- Desc (id 5, state 0x..00): reload pulse 1 cycle after accept; 2-beat packet passed; zero engine matches → one record idx 0xFFFF last=1; status count 0, flow_state = engine tail.
- Engine model with 3 matches (idx 10, 20, 30) → records 10, 20, 30, then 0xFFFF last; 3 next_index pulses, each ≥SETTLE_CYCLES+1 apart; count 3.
- res_ready held low 20 cycles during POLL → res_valid/res_index stable; no next_index pulse until handshake.
- MAX_MATCHES=2 with 4 engine matches → 2 records, 4 next_index pulses, terminal record, sts_overflow=1, count 2.
- m_axis_tready toggling 50% during STREAM → no beat lost or duplicated; s_axis_tready mirrors m_axis_tready.
- rst_n asserted in DRAIN → all outputs 0 asynchronously; the next descriptor is processed normally.
